// File: rtl/bsg_lzc_pkg.sv
// Shared types and helpers for the pipelined leading/trailing zero counter.
package bsg_lzc_pkg;

  typedef enum logic {
    e_lzc_leading  = 1'b0,
    e_lzc_trailing = 1'b1
  } lzc_mode_e;

  // Count range is 0..w inclusive, so the all-zero case needs its own code.
  function automatic int lzc_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bsg_lzc_comb.sv
// Combinational zero counter: trailing mode is handled by bit-reversing the
// operand so a single leading-zero priority encoder serves both modes.
module bsg_lzc_comb
  import bsg_lzc_pkg::*;
#(
  parameter  int width_p      = 16,
  localparam int cnt_width_lp = lzc_cnt_width(width_p)
) (
  input  logic [width_p-1:0]      data_i,
  input  lzc_mode_e               mode_i,
  output logic [cnt_width_lp-1:0] count_o,
  output logic                    zero_o
);

  logic [width_p-1:0] rev_s;
  logic [width_p-1:0] scan_s;

  // Bit-reverse the operand for trailing-zero counting.
  always_comb begin
    rev_s = '0;
    for (int i = 0; i < width_p; i++) begin
      rev_s[i] = data_i[width_p-1-i];
    end
  end

  assign scan_s = (mode_i == e_lzc_trailing) ? rev_s : data_i;

  // Priority encode from LSB upward so the MSB-most set bit has the final say.
  always_comb begin
    count_o = cnt_width_lp'(width_p);
    for (int i = 0; i < width_p; i++) begin
      count_o = scan_s[i] ? cnt_width_lp'(width_p - 1 - i) : count_o;
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/bsg_lzc_normalize_pipe.sv
// Two-stage zero counter + normalizer with valid/ready handshake.
// S1 holds operand and count; S2 holds the shifted result.
module bsg_lzc_normalize_pipe
  import bsg_lzc_pkg::*;
#(
  parameter  int width_p      = 16,
  localparam int cnt_width_lp = lzc_cnt_width(width_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [width_p-1:0]      data_i,
  input  logic                    mode_i,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic [cnt_width_lp-1:0] count_o,
  output logic                    zero_o,
  output logic [width_p-1:0]      norm_o,
  output logic                    mode_o
);

  logic                    s1_v_q,    s1_v_d;
  logic [width_p-1:0]      s1_data_q, s1_data_d;
  lzc_mode_e               s1_mode_q, s1_mode_d;
  logic [cnt_width_lp-1:0] s1_cnt_q,  s1_cnt_d;
  logic                    s1_zero_q, s1_zero_d;

  logic                    s2_v_q,    s2_v_d;
  logic [width_p-1:0]      s2_norm_q, s2_norm_d;
  lzc_mode_e               s2_mode_q, s2_mode_d;
  logic [cnt_width_lp-1:0] s2_cnt_q,  s2_cnt_d;
  logic                    s2_zero_q, s2_zero_d;

  lzc_mode_e               mode_in_s;
  logic [cnt_width_lp-1:0] cnt_s;
  logic                    zero_s;
  logic [width_p-1:0]      shift_s;
  logic                    s1_load_s;
  logic                    s2_load_s;

  assign mode_in_s = lzc_mode_e'(mode_i);

  bsg_lzc_comb #(
    .width_p(width_p)
  ) u_comb (
    .data_i (data_i),
    .mode_i (mode_in_s),
    .count_o(cnt_s),
    .zero_o (zero_s)
  );

  // An empty stage never blocks the one behind it, so bubbles collapse.
  assign s2_load_s = ~s2_v_q | ready_i;
  assign s1_load_s = ~s1_v_q | s2_load_s;
  assign ready_o   = s1_load_s;

  // S1 next state: capture operand, mode and count on an accepted beat.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_mode_d = s1_mode_q;
    s1_cnt_d  = s1_cnt_q;
    s1_zero_d = s1_zero_q;
    if (s1_load_s) begin
      s1_v_d = v_i;
      if (v_i) begin
        s1_data_d = data_i;
        s1_mode_d = mode_in_s;
        s1_cnt_d  = cnt_s;
        s1_zero_d = zero_s;
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_v_d = s1_v_q;
    end
  end

  // S2 barrel shift; a count of width_p shifts everything out, giving 0.
  always_comb begin
    if (s1_mode_q == e_lzc_trailing) begin
      shift_s = s1_data_q >> s1_cnt_q;
    end else begin
      shift_s = s1_data_q << s1_cnt_q;
    end
  end

  // S2 next state: take S1's result whenever the output slot is free.
  always_comb begin
    s2_v_d    = s2_v_q;
    s2_norm_d = s2_norm_q;
    s2_mode_d = s2_mode_q;
    s2_cnt_d  = s2_cnt_q;
    s2_zero_d = s2_zero_q;
    if (s2_load_s) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_norm_d = shift_s;
        s2_mode_d = s1_mode_q;
        s2_cnt_d  = s1_cnt_q;
        s2_zero_d = s1_zero_q;
      end else begin
        s2_norm_d = s2_norm_q;
      end
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Stage registers; reset drops in-flight beats and clears all data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_mode_q <= e_lzc_leading;
      s1_cnt_q  <= '0;
      s1_zero_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_norm_q <= '0;
      s2_mode_q <= e_lzc_leading;
      s2_cnt_q  <= '0;
      s2_zero_q <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_mode_q <= s1_mode_d;
      s1_cnt_q  <= s1_cnt_d;
      s1_zero_q <= s1_zero_d;
      s2_v_q    <= s2_v_d;
      s2_norm_q <= s2_norm_d;
      s2_mode_q <= s2_mode_d;
      s2_cnt_q  <= s2_cnt_d;
      s2_zero_q <= s2_zero_d;
    end
  end

  assign v_o     = s2_v_q;
  assign count_o = s2_cnt_q;
  assign zero_o  = s2_zero_q;
  assign norm_o  = s2_norm_q;
  assign mode_o  = s2_mode_q;

endmodule

// File: tb/tb_bsg_lzc_normalize_pipe.sv
// Bench: directed checks on a 16-bit instance, randomized scoreboard run on a 13-bit one.
module tb_bsg_lzc_normalize_pipe;

  logic clk;
  logic reset_i;

  logic        a_v_i, a_ready_o, a_ready_i, a_v_o, a_mode_i, a_zero_o, a_mode_o;
  logic [15:0] a_data_i, a_norm_o;
  logic [4:0]  a_count_o;

  logic        b_v_i, b_ready_o, b_ready_i, b_v_o, b_mode_i, b_zero_o, b_mode_o;
  logic [12:0] b_data_i, b_norm_o;
  logic [3:0]  b_count_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cnt;
    logic [31:0] norm;
    logic        zero;
    logic        mode;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic        acc, cons;
  logic [31:0] d;
  logic [15:0] outs_cnt[8];
  logic [15:0] outs_norm[8];
  int          idx, nout, ngen, r, mcnt;
  logic [31:0] mnorm;

  bsg_lzc_normalize_pipe #(.width_p(16)) dut_a (
    .clk_i(clk), .reset_i(reset_i), .v_i(a_v_i), .ready_o(a_ready_o),
    .data_i(a_data_i), .mode_i(a_mode_i), .v_o(a_v_o), .ready_i(a_ready_i),
    .count_o(a_count_o), .zero_o(a_zero_o), .norm_o(a_norm_o), .mode_o(a_mode_o)
  );

  bsg_lzc_normalize_pipe #(.width_p(13)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .v_i(b_v_i), .ready_o(b_ready_o),
    .data_i(b_data_i), .mode_i(b_mode_i), .v_o(b_v_o), .ready_i(b_ready_i),
    .count_o(b_count_o), .zero_o(b_zero_o), .norm_o(b_norm_o), .mode_o(b_mode_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count zeros from the chosen end by walking bit positions.
  function automatic void model(input int w, input logic [31:0] din, input logic m,
                                output int cnt, output logic [31:0] norm);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (32'h1 << w) - 32'h1;
    v    = din & mask;
    cnt  = 0;
    if (v == 32'h0) begin
      cnt  = w;
      norm = 32'h0;
    end else if (m == 1'b0) begin
      while (((v >> (w - 1 - cnt)) & 32'h1) == 32'h0) cnt++;
      norm = (v << cnt) & mask;
    end else begin
      while (((v >> cnt) & 32'h1) == 32'h0) cnt++;
      norm = v >> cnt;
    end
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_v_o"},     {31'h0, a_v_o},     32'h0);
    chk({tag, "_ready_o"}, {31'h0, a_ready_o}, 32'h1);
    chk({tag, "_count_o"}, {27'h0, a_count_o}, 32'h0);
    chk({tag, "_zero_o"},  {31'h0, a_zero_o},  32'h0);
    chk({tag, "_norm_o"},  {16'h0, a_norm_o},  32'h0);
    chk({tag, "_mode_o"},  {31'h0, a_mode_o},  32'h0);
  endtask

  // Single beat on the 16-bit DUT into an empty pipe with ready_i high.
  task automatic one16(input string tag, input logic [15:0] din, input logic m,
                       input int exp_cnt, input logic [15:0] exp_norm, input logic exp_zero);
    a_v_i     = 1'b1;
    a_data_i  = din;
    a_mode_i  = m;
    a_ready_i = 1'b1;
    #1;
    chk({tag, "_ready"}, {31'h0, a_ready_o}, 32'h1);
    @(posedge clk); #1;
    a_v_i = 1'b0;
    chk({tag, "_lat1_v"}, {31'h0, a_v_o}, 32'h0);
    @(posedge clk); #1;
    chk({tag, "_v"},     {31'h0, a_v_o},     32'h1);
    chk({tag, "_count"}, {27'h0, a_count_o}, exp_cnt);
    chk({tag, "_norm"},  {16'h0, a_norm_o},  {16'h0, exp_norm});
    chk({tag, "_zero"},  {31'h0, a_zero_o},  {31'h0, exp_zero});
    chk({tag, "_mode"},  {31'h0, a_mode_o},  {31'h0, m});
  endtask

  initial begin
    reset_i = 1'b1;
    a_v_i = 1'b0; a_data_i = 16'h0; a_mode_i = 1'b0; a_ready_i = 1'b0;
    b_v_i = 1'b0; b_data_i = 13'h0; b_mode_i = 1'b0; b_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst_during");
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("rst_after");

    one16("lead_0100",  16'h0100, 1'b0, 7,  16'h8000, 1'b0);
    one16("trail_0100", 16'h0100, 1'b1, 8,  16'h0001, 1'b0);
    one16("trail_8000", 16'h8000, 1'b1, 15, 16'h0001, 1'b0);
    one16("lead_zero",  16'h0000, 1'b0, 16, 16'h0000, 1'b1);
    one16("trail_zero", 16'h0000, 1'b1, 16, 16'h0000, 1'b1);
    one16("lead_8000",  16'h8000, 1'b0, 0,  16'h8000, 1'b0);
    one16("trail_0001", 16'h0001, 1'b1, 0,  16'h0001, 1'b0);

    // Backpressure: two beats fill the pipe, five full-stall cycles, then drain.
    @(posedge clk); #1;
    idx = 0; nout = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      a_v_i     = (idx < 4);
      a_data_i  = 16'h1 << idx;
      a_mode_i  = 1'b0;
      a_ready_i = (cyc >= 7);
      #1;
      if (cyc >= 2 && cyc <= 6) begin
        chk("bp_ready_low", {31'h0, a_ready_o}, 32'h0);
        chk("bp_v_hold",    {31'h0, a_v_o},     32'h1);
        chk("bp_cnt_hold",  {27'h0, a_count_o}, 32'd15);
        chk("bp_norm_hold", {16'h0, a_norm_o},  32'h8000);
      end
      if (cyc == 2) chk("bp_accepts", idx, 2);
      acc  = a_v_i & a_ready_o;
      cons = a_v_o & a_ready_i;
      if (cons && nout < 8) begin
        outs_cnt[nout]  = {11'h0, a_count_o};
        outs_norm[nout] = a_norm_o;
        nout++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    a_v_i = 1'b0;
    chk("bp_nout", nout, 4);
    for (int k = 0; k < 4; k++) begin
      chk("bp_cnt_order", {16'h0, outs_cnt[k]}, 15 - k);
      chk("bp_norm",      {16'h0, outs_norm[k]}, 32'h8000);
    end

    // Reset with both stages full.
    a_ready_i = 1'b0;
    a_v_i = 1'b1; a_data_i = 16'h00F0; a_mode_i = 1'b0;
    @(posedge clk); #1;
    a_data_i = 16'h0F00; a_mode_i = 1'b1;
    @(posedge clk); #1;
    a_v_i = 1'b0;
    chk("pre_rst_v",     {31'h0, a_v_o},     32'h1);
    chk("pre_rst_ready", {31'h0, a_ready_o}, 32'h0);
    #2;
    reset_i = 1'b1;
    #1;
    chk_reset_outs("midrst");
    @(posedge clk); #1;
    chk_reset_outs("midrst_hold");
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("midrst_rel");
    one16("post_rst", 16'h0010, 1'b0, 11, 16'h8000, 1'b0);
    @(posedge clk); #1;
    chk("post_rst_empty", {31'h0, a_v_o}, 32'h0);

    // Randomized run on the 13-bit instance against the scoreboard.
    ngen = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!b_v_i) begin
        b_v_i = ($urandom_range(0, 3) != 0);
        if (b_v_i) begin
          r = $urandom_range(0, 7);
          if (r == 0 || (ngen % 16) == 0) d = 32'h0;
          else if (r == 1) d = 32'h1 << $urandom_range(0, 12);
          else d = $urandom & 32'h1FFF;
          b_data_i = d[12:0];
          b_mode_i = 1'($urandom_range(0, 1));
          ngen++;
        end
      end
      b_ready_i = ($urandom_range(0, 2) != 0);
      #1;
      acc  = b_v_i & b_ready_o;
      cons = b_v_o & b_ready_i;
      if (cons) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("rnd_count", {28'h0, b_count_o}, e.cnt);
          chk("rnd_norm",  {19'h0, b_norm_o},  e.norm);
          chk("rnd_zero",  {31'h0, b_zero_o},  {31'h0, e.zero});
          chk("rnd_mode",  {31'h0, b_mode_o},  {31'h0, e.mode});
        end
      end
      if (acc) begin
        model(13, {19'h0, b_data_i}, b_mode_i, mcnt, mnorm);
        e.cnt  = mcnt;
        e.norm = mnorm;
        e.zero = (b_data_i == 13'h0);
        e.mode = b_mode_i;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (acc) b_v_i = 1'b0;
    end
    b_v_i = 1'b0;
    b_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (b_v_o) begin
        if (sb.size() == 0) begin
          chk("drain_underflow", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("drain_count", {28'h0, b_count_o}, e.cnt);
          chk("drain_norm",  {19'h0, b_norm_o},  e.norm);
          chk("drain_zero",  {31'h0, b_zero_o},  {31'h0, e.zero});
          chk("drain_mode",  {31'h0, b_mode_o},  {31'h0, e.mode});
        end
      end
      @(posedge clk);
    end
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
